// File: rtl/mem_load_unit.sv
// mem_load_unit: memory-stage load engine.
// Accepts one load from EX/MEM and issues a word read over a req/ack handshake.
// It then extracts, extends and byte-merges the returned word with the old rt value.
// The result is presented to writeback over a valid/ready handshake.
// Memory is big-endian: byte offset 0 is word bits [31:24].
//
// Ports:
//   clk, reset                       clock, async active-high reset
//   ld_valid/ld_ready                load request handshake (ld_ready = IDLE)
//   ld_addr, ld_sel, ld_b_w_en,      load address, type (0 LW, 1 LB, 2 LBU,
//   ld_rt_old, ld_dst                3 LH, 4 LHU, 5 LWL, 6 LWR, 7 LW),
//                                    byte enables, old rt value, destination
//   mem_req/mem_ack, mem_addr,       word read handshake to data memory
//   mem_rdata
//   flush                            squash the in-flight load
//   wb_valid/wb_ready, wb_data,      result handshake to writeback
//   wb_dst, wb_b_w_en
module mem_load_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  ld_sel,
    input  logic [3:0]  ld_b_w_en,
    input  logic [31:0] ld_rt_old,
    input  logic [4:0]  ld_dst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        flush,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_dst,
    output logic [3:0]  wb_b_w_en
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [1:0]  k_r;
    logic [2:0]  sel_r;
    logic [31:0] rt_r;
    logic        mem_req_r;
    logic        wb_valid_r;
    logic [31:0] mem_addr_r;
    logic [31:0] wb_data_r;
    logic [4:0]  wb_dst_r;
    logic [3:0]  wb_b_w_en_r;
    logic        accept_s;
    logic        ack_s;

    // Pick the addressed byte/half/word and extend or shift it into place.
    function automatic logic [31:0] extract_word(input logic [31:0] w,
                                                 input logic [1:0]  k,
                                                 input logic [2:0]  sel);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (k)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            2'd3:    b = w[7:0];
            default: b = w[31:24];
        endcase
        // k[0] is deliberately ignored for halfwords: no alignment trap.
        h = k[1] ? w[15:0] : w[31:16];
        case (sel)
            3'd1:    r = {{24{b[7]}}, b};
            3'd2:    r = {24'd0, b};
            3'd3:    r = {{16{h[15]}}, h};
            3'd4:    r = {16'd0, h};
            3'd5:    r = w << {k, 3'b000};
            3'd6:    r = w >> {2'd3 - k, 3'b000};
            default: r = w;
        endcase
        return r;
    endfunction

    // Byte-wise select between the extracted word and the old rt value.
    function automatic logic [31:0] merge_bytes(input logic [31:0] ext,
                                                input logic [31:0] rt,
                                                input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? ext[8*i +: 8] : rt[8*i +: 8];
        end
        return r;
    endfunction

    // ack is only meaningful while a request is outstanding in REQ.
    assign accept_s = (state_r == IDLE) && ld_valid && !flush;
    assign ack_s    = (state_r == REQ) && mem_ack;

    // Next-state logic, including squash handling in each state.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = REQ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    next_state_s = flush ? IDLE : RESP;
                end else if (flush) begin
                    // The read cannot be withdrawn; wait it out.
                    next_state_s = DRAIN;
                end else begin
                    next_state_s = REQ;
                end
            end
            RESP: begin
                if (flush || wb_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register with handshake outputs registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            mem_req_r  <= 1'b0;
            wb_valid_r <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            mem_req_r  <= (next_state_s == REQ) || (next_state_s == DRAIN);
            wb_valid_r <= (next_state_s == RESP);
        end
    end

    // Load context captured on accept; merged result captured on ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_r         <= 2'd0;
            sel_r       <= 3'd0;
            rt_r        <= 32'd0;
            mem_addr_r  <= 32'd0;
            wb_dst_r    <= 5'd0;
            wb_b_w_en_r <= 4'd0;
            wb_data_r   <= 32'd0;
        end else begin
            if (accept_s) begin
                k_r         <= ld_addr[1:0];
                sel_r       <= ld_sel;
                rt_r        <= ld_rt_old;
                mem_addr_r  <= {ld_addr[31:2], 2'b00};
                wb_dst_r    <= ld_dst;
                wb_b_w_en_r <= ld_b_w_en;
            end
            if (ack_s && !flush) begin
                wb_data_r <= merge_bytes(extract_word(mem_rdata, k_r, sel_r),
                                         rt_r, wb_b_w_en_r);
            end
        end
    end

    assign ld_ready  = (state_r == IDLE);
    assign mem_req   = mem_req_r;
    assign mem_addr  = mem_addr_r;
    assign wb_valid  = wb_valid_r;
    assign wb_data   = wb_data_r;
    assign wb_dst    = wb_dst_r;
    assign wb_b_w_en = wb_b_w_en_r;

endmodule

// File: tb/tb_mem_load_unit.sv
// Self-checking bench for mem_load_unit: directed loads with a result
// scoreboard, plus latency/backpressure, flush and reset scenarios.
module tb_mem_load_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_addr;
    logic [2:0]  ld_sel;
    logic [3:0]  ld_b_w_en;
    logic [31:0] ld_rt_old;
    logic [4:0]  ld_dst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        flush;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_dst;
    logic [3:0]  wb_b_w_en;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  dst;
        logic [3:0]  be;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    mem_load_unit dut (
        .clk       (clk),
        .reset     (reset),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_sel    (ld_sel),
        .ld_b_w_en (ld_b_w_en),
        .ld_rt_old (ld_rt_old),
        .ld_dst    (ld_dst),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .flush     (flush),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_data   (wb_data),
        .wb_dst    (wb_dst),
        .wb_b_w_en (wb_b_w_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full load: accept, hold ack off for ack_dly extra cycles, hold wb_ready
    // off for rdy_dly cycles, then pop the scoreboard at the handoff.
    task automatic run_load(input logic [31:0] addr, input logic [2:0] sel,
                            input logic [3:0] be, input logic [31:0] rt,
                            input logic [4:0] dst, input logic [31:0] rdata,
                            input logic [31:0] exp_data,
                            input int ack_dly, input int rdy_dly);
        exp_t e;
        @(negedge clk);
        chk("ld_ready_idle", ld_ready, 32'd1);
        ld_valid  = 1'b1;
        ld_addr   = addr;
        ld_sel    = sel;
        ld_b_w_en = be;
        ld_rt_old = rt;
        ld_dst    = dst;
        e.data = exp_data;
        e.dst  = dst;
        e.be   = be;
        sb_q.push_back(e);
        @(negedge clk);
        ld_valid  = 1'b0;
        ld_addr   = $urandom();
        ld_rt_old = $urandom();
        ld_b_w_en = 4'($urandom());
        chk("mem_req_rise", mem_req, 32'd1);
        chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
        chk("ld_ready_busy", ld_ready, 32'd0);
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            chk("mem_req_hold", mem_req, 32'd1);
            chk("mem_addr_hold", mem_addr, {addr[31:2], 2'b00});
            chk("wb_valid_wait", wb_valid, 32'd0);
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = $urandom();
        chk("mem_req_drop", mem_req, 32'd0);
        for (int i = 0; i < rdy_dly; i++) begin
            chk("wb_valid_stall", wb_valid, 32'd1);
            chk("wb_data_stall", wb_data, exp_data);
            @(negedge clk);
        end
        wb_ready = 1'b1;
        chk("wb_valid", wb_valid, 32'd1);
        chk("sb_nonempty", (sb_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("wb_data", wb_data, e.data);
            chk("wb_dst", {27'd0, wb_dst}, {27'd0, e.dst});
            chk("wb_b_w_en", {28'd0, wb_b_w_en}, {28'd0, e.be});
        end
        @(negedge clk);
        wb_ready = 1'b0;
        chk("wb_valid_drop", wb_valid, 32'd0);
        chk("ld_ready_after", ld_ready, 32'd1);
    endtask

    // Accept a load without scoreboard entry (for squash scenarios).
    task automatic accept_only(input logic [31:0] addr);
        @(negedge clk);
        ld_valid  = 1'b1;
        ld_addr   = addr;
        ld_sel    = 3'd0;
        ld_b_w_en = 4'hF;
        ld_rt_old = 32'h0;
        ld_dst    = 5'd9;
        @(negedge clk);
        ld_valid  = 1'b0;
        chk("sq_mem_req", mem_req, 32'd1);
    endtask

    initial begin
        reset = 1'b1; ld_valid = 1'b0; ld_addr = 32'd0; ld_sel = 3'd0;
        ld_b_w_en = 4'd0; ld_rt_old = 32'd0; ld_dst = 5'd0; mem_ack = 1'b0;
        mem_rdata = 32'd0; flush = 1'b0; wb_ready = 1'b0;
        #12;
        chk("rst_ld_ready", ld_ready, 32'd1);
        chk("rst_mem_req", mem_req, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_wb_valid", wb_valid, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Extraction and merge cases.
        run_load(32'h0000_0002, 3'd1, 4'hF, 32'h0, 5'd1, 32'h8899AABB, 32'hFFFFFFAA, 0, 0);
        run_load(32'h0000_0002, 3'd2, 4'hF, 32'h0, 5'd2, 32'h8899AABB, 32'h000000AA, 0, 0);
        run_load(32'h0000_0002, 3'd3, 4'hF, 32'h0, 5'd3, 32'h8899AABB, 32'hFFFFAABB, 0, 0);
        run_load(32'h0000_0001, 3'd4, 4'hF, 32'h0, 5'd4, 32'h8899AABB, 32'h00008899, 1, 0);
        run_load(32'h0000_0001, 3'd5, 4'hE, 32'hDEADBEEF, 5'd5, 32'h11223344, 32'h223344EF, 0, 1);
        run_load(32'h0000_0000, 3'd5, 4'hF, 32'hDEADBEEF, 5'd6, 32'h11223344, 32'h11223344, 0, 0);
        run_load(32'h0000_0001, 3'd6, 4'h3, 32'hDEADBEEF, 5'd7, 32'h11223344, 32'hDEAD1122, 0, 0);
        run_load(32'h0000_0003, 3'd6, 4'hF, 32'hDEADBEEF, 5'd8, 32'h11223344, 32'h11223344, 0, 0);
        run_load(32'h0000_0103, 3'd7, 4'hF, 32'h0, 5'd9, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0);
        run_load(32'h0000_0040, 3'd1, 4'h1, 32'h12345678, 5'd10, 32'h8899AABB, 32'h12345688, 0, 0);
        run_load(32'h0000_0044, 3'd0, 4'h0, 32'hA5A5A5A5, 5'd11, 32'h01020304, 32'hA5A5A5A5, 0, 0);
        // Variable latency (ack 4 cycles after mem_req) and 3 cycles of backpressure.
        run_load(32'h8000_1236, 3'd3, 4'hF, 32'h0, 5'd31, 32'h7F00_8001, 32'hFFFF8001, 3, 3);

        // Flush in IDLE blocks acceptance.
        @(negedge clk);
        ld_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        ld_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_mem_req", mem_req, 32'd0);
        chk("idle_flush_ld_ready", ld_ready, 32'd1);

        // Flush in REQ without ack: drain; flush during DRAIN is ignored.
        accept_only(32'h0000_0020);
        flush = 1'b1;
        @(negedge clk);
        chk("drain_mem_req", mem_req, 32'd1);
        chk("drain_ld_ready", ld_ready, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("drain_mem_req2", mem_req, 32'd1);
        chk("drain_wb_valid", wb_valid, 32'd0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("drain_done_mem_req", mem_req, 32'd0);
        chk("drain_done_ld_ready", ld_ready, 32'd1);
        chk("drain_done_wb_valid", wb_valid, 32'd0);

        // Flush with ack on the same edge: straight to IDLE.
        accept_only(32'h0000_0024);
        flush = 1'b1; mem_ack = 1'b1;
        @(negedge clk);
        flush = 1'b0; mem_ack = 1'b0;
        chk("fa_mem_req", mem_req, 32'd0);
        chk("fa_wb_valid", wb_valid, 32'd0);
        chk("fa_ld_ready", ld_ready, 32'd1);

        // Flush in RESP drops wb_valid even with wb_ready high.
        accept_only(32'h0000_0028);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("fr_wb_valid", wb_valid, 32'd1);
        flush = 1'b1; wb_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; wb_ready = 1'b0;
        chk("fr_wb_valid_drop", wb_valid, 32'd0);
        chk("fr_ld_ready", ld_ready, 32'd1);

        // Reset mid-REQ, then a late ack.
        accept_only(32'h0000_00F0);
        #2 reset = 1'b1;
        #1;
        chk("mr_mem_req", mem_req, 32'd0);
        chk("mr_mem_addr", mem_addr, 32'd0);
        chk("mr_wb_data", wb_data, 32'd0);
        chk("mr_wb_dst", {27'd0, wb_dst}, 32'd0);
        chk("mr_wb_b_w_en", {28'd0, wb_b_w_en}, 32'd0);
        chk("mr_ld_ready", ld_ready, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_wb_valid", wb_valid, 32'd0);
        chk("late_ack_mem_req", mem_req, 32'd0);
        @(negedge clk);
        chk("late_ack_wb_valid2", wb_valid, 32'd0);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_load_unit.md
# mem_load_unit

Memory-stage load engine for the MIPS pipeline. It accepts one load from the EX/MEM boundary together with the byte-write enables already computed for that load. It issues a word read to data memory over a req/ack handshake and waits a variable number of cycles for the response. It then extracts, extends and byte-merges the returned word with the old rt value, and presents the result to writeback over a valid/ready handshake. Memory byte order is big-endian: byte offset 0 is word bits [31:24].

## Interface
Parameters: none.
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- ld_valid  in  1  load request present
- ld_ready  out  1  high iff state is IDLE; a load is accepted on an edge where ld_valid & ld_ready & !flush
- ld_addr  in  32  byte address
- ld_sel  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 treated as LW
- ld_b_w_en  in  4  per-byte register write enables, bit i = result byte i (bits [8i+7:8i])
- ld_rt_old  in  32  current rt value, used for bytes with enable 0
- ld_dst  in  5  destination register number
- mem_req  out  1  read request, held until acknowledged
- mem_addr  out  32  {ld_addr[31:2], 2'b00}, stable while mem_req
- mem_ack  in  1  response strobe; mem_rdata valid when mem_ack & mem_req
- mem_rdata  in  32  returned word
- flush  in  1  kill the in-flight load (exception/branch squash)
- wb_valid  out  1  result available
- wb_ready  in  1  writeback consumes result
- wb_data  out  32  merged register value
- wb_dst  out  5  destination register
- wb_b_w_en  out  4  enables carried with the result

## Operation
- States: IDLE, REQ, RESP, DRAIN. On reset: state IDLE, mem_req 0, mem_addr 0, wb_valid 0, wb_data 0, wb_dst 0, wb_b_w_en 0. ld_ready reads 1 during and after reset.
- IDLE: on accept, latch addr[1:0], sel, b_w_en, rt_old and dst; drive mem_addr; go to REQ.
- REQ: mem_req=1. Stay until mem_ack. On ack, compute the result from mem_rdata and go to RESP.
- RESP: wb_valid=1, with outputs stable. On wb_ready, go to IDLE.
- DRAIN: mem_req=1 (the request cannot be withdrawn). On ack, discard the data and go to IDLE. flush is ignored here.
- Flush behaviour by state:
  - IDLE: blocks acceptance.
  - REQ without ack: go to DRAIN.
  - REQ with ack on the same edge: go to IDLE, no result.
  - RESP: go to IDLE, wb_valid drops next cycle, even if wb_ready was high.
- Extraction, with w = mem_rdata and k = addr[1:0]:
  - LB/LBU: byte w[31-8k -: 8], sign-/zero-extended.
  - LH/LHU: half w[31:16] if k[1]=0, else w[15:0], sign-/zero-extended. k[0] is ignored; no alignment trap.
  - LW: w.
  - LWL: w << 8k.
  - LWR: w >> 8(3-k).
- Merge: wb_data byte i = ld_b_w_en[i] ? extracted byte i : rt_old byte i. Enables are applied as given for every ld_sel, with no internal override.

## Timing
- Accept edge to mem_req high: 1 cycle.
- Ack edge to wb_valid high: 1 cycle. Minimum latency from accept to wb_valid is 2 cycles.
- Handoff edge to ld_ready high: 1 cycle, so throughput is at most one load per 3 cycles. There is no bypass of IDLE.
- mem_ack while mem_req=0 is ignored.
- wb_ready while wb_valid=0 is ignored.
- Reset mid-operation returns to IDLE immediately and drops mem_req asynchronously. A late ack after reset is ignored.

## Test plan
- LB/LBU sign extension: mem_rdata 0x8899AABB, addr 2, be 1111. LB gives wb_data 0xFFFFFFAA; LBU gives 0x000000AA; LH at addr 2 gives 0xFFFFAABB.
- LWL merge: rdata 0x11223344, addr 1, be 1110, rt_old 0xDEADBEEF gives 0x223344EF. The same load with addr 0 and be 1111 gives 0x11223344.
- LWR merge: rdata 0x11223344, addr 1, be 0011, rt_old 0xDEADBEEF gives 0xDEAD1122. With addr 3 and be 1111 the result is 0x11223344.
- Variable latency and backpressure: ack arrives 4 cycles after mem_req rises, and wb_ready is held low 3 cycles. mem_req, mem_addr, wb_valid and wb_data all stay stable. ld_ready returns 1 cycle after the wb handoff.
- Flush in REQ: flush 1 cycle after mem_req rises, ack 2 cycles later. mem_req stays high until the ack, wb_valid never asserts, and ld_ready rises the cycle after the ack. Flush with ack on the same edge goes straight to IDLE.
- Reset mid-REQ: assert reset while mem_req=1. All outputs go to their reset values asynchronously, and a subsequent ack produces no wb_valid.
